// File: rtl/alu_seq.sv
// Registered N-bit ALU: single-cycle arithmetic/logic/shift ops plus an N-cycle
// restoring divider for DIV/MOD, with held result, flags and a one-cycle done pulse.
module alu_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_DIV = 4'd2, OP_MOD = 4'd3,
                         OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_SHL = 4'd7,
                         OP_SHR = 4'd8, OP_ASR = 4'd9;
  localparam logic [N:0] N_VAL = (N+1)'(N);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DIV = 1'b1} state_t;

  state_t          state_r, state_next_s;
  logic [N-1:0]    quo_r, rem_r, div_r;
  logic [CW-1:0]   cnt_r;
  logic            mod_r;

  logic [N:0]      sum_s, shl_s, shr_s, asr_s, trial_s;
  logic [N-1:0]    diff_s, rem_step_s, quo_step_s;
  logic            start_div_s, last_s, shift_ok_s;
  logic [N-1:0]    alu_res_s, res_next_s;
  logic [3:0]      alu_flg_s, flg_next_s;
  logic            alu_c_s, alu_v_s, alu_legal_s;
  logic            upd_s, load_s, busy_next_s;

  // Z and N flag bits {N, Z} derived from a result word.
  function automatic logic [1:0] nz_bits(input logic [N-1:0] r);
    return {r[N-1], (r == {N{1'b0}})};
  endfunction

  assign sum_s       = {1'b0, a} + {1'b0, b};
  assign diff_s      = a - b;
  assign shl_s       = {1'b0, a} << b;
  assign shr_s       = {a, 1'b0} >> b;
  assign asr_s       = $signed({a, 1'b0}) >>> b;
  assign shift_ok_s  = ({1'b0, b} < N_VAL);
  assign start_div_s = ((op == OP_DIV) || (op == OP_MOD)) && (b != {N{1'b0}});
  assign last_s      = (cnt_r == CW'(N-1));

  // Restoring step: a negative trial (bit N set) keeps the shifted remainder.
  assign trial_s    = {rem_r, quo_r[N-1]} - {1'b0, div_r};
  assign rem_step_s = trial_s[N] ? {rem_r[N-2:0], quo_r[N-1]} : trial_s[N-1:0];
  assign quo_step_s = {quo_r[N-2:0], ~trial_s[N]};

  // Single-cycle result and flags, including the divide-by-zero outcomes.
  always_comb begin
    alu_res_s   = {N{1'b0}};
    alu_c_s     = 1'b0;
    alu_v_s     = 1'b0;
    alu_legal_s = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res_s = sum_s[N-1:0];
        alu_c_s   = sum_s[N];
        alu_v_s   = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_c_s   = (a < b);
        alu_v_s   = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
      end
      OP_DIV: begin
        alu_res_s = {N{1'b1}};
        alu_v_s   = 1'b1;
      end
      OP_MOD: begin
        alu_res_s = a;
        alu_v_s   = 1'b1;
      end
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_SHL: begin
        if (shift_ok_s) begin
          alu_res_s = shl_s[N-1:0];
          alu_c_s   = shl_s[N];
        end else begin
          alu_res_s = {N{1'b0}};
        end
      end
      OP_SHR: begin
        if (shift_ok_s) begin
          alu_res_s = shr_s[N:1];
          alu_c_s   = shr_s[0];
        end else begin
          alu_res_s = {N{1'b0}};
        end
      end
      OP_ASR: begin
        if (shift_ok_s) begin
          alu_res_s = asr_s[N:1];
          alu_c_s   = asr_s[0];
        end else begin
          alu_res_s = {N{a[N-1]}};
        end
      end
      default: alu_legal_s = 1'b0;
    endcase
    if (alu_legal_s) begin
      alu_flg_s = {alu_v_s, nz_bits(alu_res_s), alu_c_s};
    end else begin
      alu_flg_s = 4'b0000;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && start_div_s) state_next_s = ST_DIV;
        else                      state_next_s = ST_IDLE;
      end
      ST_DIV: begin
        if (last_s) state_next_s = ST_IDLE;
        else        state_next_s = ST_DIV;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output/update decode: what the output registers take at the next edge.
  always_comb begin
    upd_s       = 1'b0;
    load_s      = 1'b0;
    busy_next_s = 1'b0;
    res_next_s  = alu_res_s;
    flg_next_s  = alu_flg_s;
    case (state_r)
      ST_IDLE: begin
        if (start && start_div_s) begin
          load_s      = 1'b1;
          busy_next_s = 1'b1;
        end else if (start) begin
          upd_s = 1'b1;
        end else begin
          upd_s = 1'b0;
        end
      end
      ST_DIV: begin
        res_next_s = mod_r ? rem_step_s : quo_step_s;
        flg_next_s = {1'b0, nz_bits(res_next_s), 1'b0};
        if (last_s) begin
          upd_s = 1'b1;
        end else begin
          busy_next_s = 1'b1;
        end
      end
      default: begin
        upd_s = 1'b0;
      end
    endcase
  end

  // Output and divider registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {N{1'b0}};
      flags  <= 4'b0000;
      quo_r  <= {N{1'b0}};
      rem_r  <= {N{1'b0}};
      div_r  <= {N{1'b0}};
      cnt_r  <= {CW{1'b0}};
      mod_r  <= 1'b0;
    end else begin
      busy <= busy_next_s;
      done <= upd_s;
      if (upd_s) begin
        result <= res_next_s;
        flags  <= flg_next_s;
      end
      if (load_s) begin
        quo_r <= a;
        rem_r <= {N{1'b0}};
        div_r <= b;
        cnt_r <= {CW{1'b0}};
        mod_r <= (op == OP_MOD);
      end else if (state_r == ST_DIV) begin
        quo_r <= quo_step_s;
        rem_r <= rem_step_s;
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (N=4): stimulus pushes expected result/flags/done
// cycle; an independent monitor pops and compares on every done pulse.
module tb_alu_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done;
  logic [N-1:0] result;
  logic [3:0]   flags;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   flg;
    int           cyc;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   next_id = 0;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.id), int'(result), int'(e.res));
        chk($sformatf("flags#%0d", e.id), int'(flags), int'(e.flg));
        chk($sformatf("done_cycle#%0d", e.id), cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] er, input logic [3:0] ef, input int lat);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    e.res = er; e.flg = ef; e.cyc = cyc + lat; e.id = next_id;
    next_id++;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = 4'hA; b = 4'h5;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; a = 4'd0; b = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_flags", int'(flags), 0);

    // Back-to-back single-cycle ops (each start lands on the previous done).
    issue(4'd0, 4'd7,    4'd9,    4'b0000, 4'b0011, 1); // ADD carry, zero
    issue(4'd0, 4'd7,    4'd1,    4'b1000, 4'b1100, 1); // ADD overflow
    issue(4'd1, 4'd3,    4'd5,    4'b1110, 4'b0101, 1); // SUB borrow
    issue(4'd1, 4'd6,    4'd6,    4'b0000, 4'b0010, 1);
    issue(4'd7, 4'b1011, 4'd1,    4'b0110, 4'b0001, 1); // SHL
    issue(4'd9, 4'b1000, 4'd2,    4'b1110, 4'b0100, 1); // ASR
    issue(4'd8, 4'b1111, 4'd5,    4'b0000, 4'b0010, 1); // SHR b>=N
    issue(4'd12, 4'd3,   4'd4,    4'b0000, 4'b0000, 1); // illegal
    issue(4'd2, 4'd9,    4'd0,    4'b1111, 4'b1100, 1); // DIV by zero
    issue(4'd3, 4'd9,    4'd0,    4'b1001, 4'b1100, 1); // remainder by zero
    issue(4'd4, 4'b1100, 4'b1010, 4'b1000, 4'b0100, 1);
    issue(4'd6, 4'd5,    4'd5,    4'b0000, 4'b0010, 1);
    issue(4'd5, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 1);
    issue(4'd7, 4'b0001, 4'd0,    4'b0001, 4'b0000, 1); // SHL by 0
    issue(4'd9, 4'b1010, 4'd7,    4'b1111, 4'b0100, 1); // ASR b>=N
    issue(4'd8, 4'b0110, 4'd2,    4'b0001, 4'b0001, 1); // SHR carry
    wait_idle();

    // DIV 13/4: busy for 4 cycles, a start mid-division must be ignored.
    issue(4'd2, 4'd13, 4'd4, 4'b0011, 4'b0000, 5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("div_busy_%0d", i), int'(busy), 1);
      if (i == 1) begin
        start = 1'b1; op = 4'd0; a = 4'd1; b = 4'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("div_busy_end", int'(busy), 0);
    chk("div_done_end", int'(done), 1);
    wait_idle();

    issue(4'd3, 4'd13, 4'd4, 4'b0001, 4'b0000, 5);
    issue(4'd0, 4'd2,  4'd2, 4'b0000, 4'b0000, 0); // ignored: DUT busy
    void'(sb.pop_back());
    wait_idle();
    issue(4'd2, 4'd15, 4'd1, 4'b1111, 4'b0100, 5);
    wait_idle();
    issue(4'd3, 4'd7,  4'd3, 4'b0001, 4'b0000, 5);
    wait_idle();
    issue(4'd2, 4'd2,  4'd7, 4'b0000, 4'b0010, 5);
    wait_idle();

    // Reset during a division aborts it with no done pulse.
    start = 1'b1; op = 4'd2; a = 4'd13; b = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_flags", int'(flags), 0);
    issue(4'd0, 4'd2, 4'd3, 4'b0101, 4'b0000, 1);
    wait_idle();
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor of the lab's combinational 4-bit ALU. It captures operands and an opcode on a start strobe, computes single-cycle ops in one clock and DIV/MOD with an N-cycle restoring divider, then presents a held result with bit-wise flags and a one-cycle done pulse. It sits between the switch/button input logic and the 7-segment display decoders; display decoding is outside this block.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request strobe; sampled only when busy=0
op  in  4  opcode: 0 ADD, 1 SUB, 2 DIV, 3 MOD, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR (logical), 9 ASR (arithmetic); 10-15 illegal
a  in  N  operand A (unsigned; two's complement for V/N/ASR)
b  in  N  operand B; shift amount for SHL/SHR/ASR
busy  out  1  high while a DIV/MOD iteration is in progress
done  out  1  one-cycle pulse when result/flags update
result  out  N  last completed result, held until next completion
flags  out  4  bit0 C (carry/borrow/shift-out), bit1 Z (zero), bit2 N (negative), bit3 V (overflow/div-by-zero); multiple bits may be set

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset: busy=0, done=0, result=0, flags=0000, FSM=IDLE, divider regs cleared. rst mid-DIV aborts with no done pulse.
- FSM states: IDLE, DIV.
- IDLE, start=1: latch a, b, op. Single-cycle op or illegal op: result/flags written at that edge; done=1 the following cycle (latency 1). DIV/MOD with b!=0: go to DIV, busy=1.
- DIV: one restoring quotient bit per cycle, MSB first, N iterations. On the final iteration, write result (quotient for DIV, remainder for MOD), done=1, busy=0, return to IDLE. Total latency start-to-done = N+1 cycles.
- start while busy=1 is ignored; a and b may change freely after capture.
- done pulse lasts exactly 1 cycle. A start in the same cycle as done (busy already 0) is accepted, giving back-to-back operations.
- Z = (result==0) and N = result[N-1] for every legal op.
- ADD: (N+1)-bit sum. C = carry out. V = signed overflow (operand signs equal, result sign differs).
- SUB: a-b mod 2^N. C = borrow (a<b unsigned). V = signed overflow (operand signs differ, result sign differs from a).
- AND/OR/XOR: C=0, V=0.
- SHL/SHR: if b<N, shift by b and C = last bit shifted out (C=0 when b=0). If b>=N, result=0 and C=0. V=0.
- ASR: if b<N, sign-filled shift by b with C as above. If b>=N, result = all copies of a[N-1] and C=0. V=0.
- DIV/MOD: C=0, V=0.
- Divide by zero (b=0): no DIV state; latency 1. DIV result = all ones; MOD result = a. V=1; Z and N are computed from result.
- Illegal op: result=0, flags=0000, done pulsed, latency 1.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- N=4, ADD a=7,b=9 -> one cycle later: done=1, result=0000, flags=0011 (C,Z). ADD a=7,b=1 -> result=1000, flags=1100 (V,N).
- SUB a=3,b=5 -> result=1110, flags=0101 (C,N). SUB a=6,b=6 -> result=0000, flags=0010.
- DIV a=13,b=4 -> busy high 4 cycles, done at start+5, result=0011, flags=0000. MOD a=13,b=4 -> result=0001. start pulsed during busy -> ignored, exactly one done.
- DIV a=9,b=0 -> done at start+1, result=1111, flags=1100. MOD a=9,b=0 -> result=1001, flags=1100.
- SHL a=1011,b=1 -> result=0110, flags=0001. ASR a=1000,b=2 -> result=1110, flags=0100. SHR a=1111,b=5 -> result=0000, flags=0010. op=12 -> result=0, flags=0000, done pulse.
- DIV started, then rst asserted at cycle 2 -> next cycle busy=0, done=0, result=0, flags=0. A new ADD started immediately after completes normally.
